// File: rtl/bbox_pkg.sv
// Shared types and constants for the digit bounding-box detector and its luma front end.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package bbox_pkg;

    // Coordinate and pixel-count widths
    localparam int XW    = 11;
    localparam int YW    = 10;
    localparam int CNT_W = 21;

    // BT.601-style luma weights, scaled by 256
    localparam logic [15:0] LUMA_R = 16'd77;
    localparam logic [15:0] LUMA_G = 16'd150;
    localparam logic [15:0] LUMA_B = 16'd29;

    typedef enum logic [2:0] {
        WAIT_SYNC,
        IDLE,
        ACTIVE,
        DRAIN,
        PUBLISH
    } bbox_state_t;

    typedef struct packed {
        logic          found;
        logic          err;
        logic [XW-1:0] xmin;
        logic [XW-1:0] xmax;
        logic [YW-1:0] ymin;
        logic [YW-1:0] ymax;
    } box_t;

    // Weighted sum of 8-bit channels; the largest RGB565 expansion stays below 2^16
    function automatic logic [15:0] luma_sum(input logic [7:0] r8,
                                             input logic [7:0] g8,
                                             input logic [7:0] b8);
        return LUMA_R * {8'd0, r8} + LUMA_G * {8'd0, g8} + LUMA_B * {8'd0, b8};
    endfunction

endpackage

// File: rtl/rgb565_luma.sv
// Two-stage RGB565 to 8-bit luma converter carrying a valid/x/y sideband.
// Latency: 2 cycles from in_vld to out_vld, fully pipelined, one pixel per cycle.
// Backpressure: none; the pixel stream cannot be stalled, so every input is accepted.
module rgb565_luma
    import bbox_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic [15:0]   in_dat,
    input  logic [XW-1:0] in_x,
    input  logic [YW-1:0] in_y,
    output logic          out_vld,
    output logic [7:0]    out_dat,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y
);

    logic          s1_vld;
    logic [7:0]    s1_r;
    logic [7:0]    s1_g;
    logic [7:0]    s1_b;
    logic [XW-1:0] s1_x;
    logic [YW-1:0] s1_y;
    logic [15:0]   s1_sum;

    // Stage 1: expand each channel to 8 bits by zero-filling the LSBs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_r   <= '0;
            s1_g   <= '0;
            s1_b   <= '0;
            s1_x   <= '0;
            s1_y   <= '0;
        end else begin
            s1_vld <= in_vld;
            s1_r   <= {in_dat[15:11], 3'b000};
            s1_g   <= {in_dat[10:5],  2'b00};
            s1_b   <= {in_dat[4:0],   3'b000};
            s1_x   <= in_x;
            s1_y   <= in_y;
        end
    end

    assign s1_sum = luma_sum(s1_r, s1_g, s1_b);

    // Stage 2: weighted sum, keep the integer part
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_dat <= '0;
            out_x   <= '0;
            out_y   <= '0;
        end else begin
            out_vld <= s1_vld;
            out_dat <= s1_sum[15:8];
            out_x   <= s1_x;
            out_y   <= s1_y;
        end
    end

endmodule

// File: rtl/digit_bbox_detect.sv
// Per-frame bounding box of dark (ink) pixels; optional run-length speck filter under BBOX_NOISE_FILTER_EN.
// Latency: result pulses on Box_Valid 4 cycles after ImageState rise is sampled; pixels reach trackers in 3.
// Backpressure: none; the camera stream is never stalled and pixels outside an active frame are dropped.
module digit_bbox_detect
    import bbox_pkg::*;
#(
    parameter int         IMAGE_WIDTH  = 1280,
    parameter int         IMAGE_HEIGHT = 720,
    parameter logic [7:0] THRESH       = 8'd96
`ifdef BBOX_NOISE_FILTER_EN
    ,
    parameter int         RUN_MIN      = 3
`endif
)(
    input  logic          Clk,
    input  logic          Rst,
    input  logic          ImageState,
    input  logic          DataValid,
    input  logic [15:0]   DataPixel,
    output logic          Box_Valid,
    output logic          Box_Found,
    output logic          Frame_Err,
    output logic [XW-1:0] X_Min,
    output logic [XW-1:0] X_Max,
    output logic [YW-1:0] Y_Min,
    output logic [YW-1:0] Y_Max
);

    localparam logic [XW-1:0]    X_LAST    = XW'(IMAGE_WIDTH - 1);
    localparam logic [YW-1:0]    Y_LIM     = YW'(IMAGE_HEIGHT);
    localparam logic [CNT_W-1:0] FRAME_PIX = CNT_W'(IMAGE_WIDTH * IMAGE_HEIGHT);

    bbox_state_t      state_q;
    logic [1:0]       drain_q;
    logic             img_q;
    logic             img_fall;
    logic             frame_start;
    logic             accept;
    logic             box_vld_q;
    box_t             res_q;

    logic [XW-1:0]    x_q;
    logic [YW-1:0]    y_q;
    logic [CNT_W-1:0] pix_cnt_q;

    logic             l_vld;
    logic [7:0]       l_luma;
    logic [XW-1:0]    l_x;
    logic [YW-1:0]    l_y;
    logic             pix_dark;

    logic             upd;
    logic [XW-1:0]    x_lo;
    logic             found_q;
    logic [XW-1:0]    xmin_q;
    logic [XW-1:0]    xmax_q;
    logic [YW-1:0]    ymin_q;
    logic [YW-1:0]    ymax_q;

    assign img_fall    = img_q & ~ImageState;
    // A fall in DRAIN aborts the pending publish; a fall in PUBLISH still publishes the old frame
    assign frame_start = img_fall & ((state_q == IDLE) | (state_q == DRAIN) | (state_q == PUBLISH));
    assign accept      = DataValid & ~ImageState & (state_q == ACTIVE);

    // Previous ImageState for edge detection
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            img_q <= 1'b0;
        end else begin
            img_q <= ImageState;
        end
    end

    // Frame sequencing and registered result publication
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= WAIT_SYNC;
            drain_q   <= '0;
            box_vld_q <= 1'b0;
            res_q     <= '0;
        end else begin
            box_vld_q <= 1'b0;
            case (state_q)
                WAIT_SYNC: begin
                    if (ImageState) state_q <= IDLE;
                end
                IDLE: begin
                    if (img_fall) state_q <= ACTIVE;
                end
                ACTIVE: begin
                    if (ImageState) begin
                        state_q <= DRAIN;
                        drain_q <= '0;
                    end
                end
                DRAIN: begin
                    if (img_fall) begin
                        state_q <= ACTIVE;
                    end else if (drain_q == 2'd2) begin
                        state_q <= PUBLISH;
                    end else begin
                        drain_q <= drain_q + 2'd1;
                    end
                end
                PUBLISH: begin
                    box_vld_q  <= 1'b1;
                    res_q.found <= found_q;
                    res_q.err   <= (pix_cnt_q != FRAME_PIX);
                    res_q.xmin  <= found_q ? xmin_q : '0;
                    res_q.xmax  <= found_q ? xmax_q : '0;
                    res_q.ymin  <= found_q ? ymin_q : '0;
                    res_q.ymax  <= found_q ? ymax_q : '0;
                    state_q     <= img_fall ? ACTIVE : IDLE;
                end
                default: state_q <= WAIT_SYNC;
            endcase
        end
    end

    // Raster position and saturating pixel count; y parks at IMAGE_HEIGHT for overlong frames
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            x_q       <= '0;
            y_q       <= '0;
            pix_cnt_q <= '0;
        end else if (frame_start) begin
            x_q       <= '0;
            y_q       <= '0;
            pix_cnt_q <= '0;
        end else if (accept) begin
            if (pix_cnt_q != '1) pix_cnt_q <= pix_cnt_q + CNT_W'(1);
            if (x_q == X_LAST) begin
                x_q <= '0;
                if (y_q != Y_LIM) y_q <= y_q + YW'(1);
            end else begin
                x_q <= x_q + XW'(1);
            end
        end
    end

    rgb565_luma u_luma (
        .clk     (Clk),
        .rst     (Rst),
        .in_vld  (accept & (y_q < Y_LIM)),
        .in_dat  (DataPixel),
        .in_x    (x_q),
        .in_y    (y_q),
        .out_vld (l_vld),
        .out_dat (l_luma),
        .out_x   (l_x),
        .out_y   (l_y)
    );

    assign pix_dark = l_vld & (l_luma < THRESH);

`ifdef BBOX_NOISE_FILTER_EN
    localparam logic [7:0] RUN_TOP = 8'(RUN_MIN);

    logic [7:0] run_q;
    logic [7:0] run_nxt;

    // Length of the current dark run within a line, saturating at RUN_MIN
    always_comb begin
        run_nxt = '0;
        if (pix_dark) begin
            if (l_x == '0)            run_nxt = 8'd1;
            else if (run_q < RUN_TOP) run_nxt = run_q + 8'd1;
            else                      run_nxt = run_q;
        end
    end

    // Run counter state, restarted with every frame
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            run_q <= '0;
        end else if (frame_start) begin
            run_q <= '0;
        end else if (l_vld) begin
            run_q <= run_nxt;
        end
    end

    // A qualifying run contributes its first column as the left edge
    assign upd  = pix_dark & (run_nxt == RUN_TOP);
    assign x_lo = l_x - XW'(RUN_MIN - 1);
`else
    assign upd  = pix_dark;
    assign x_lo = l_x;
`endif

    // Min/max trackers; frame_start wins over a late pixel of the previous frame
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            found_q <= 1'b0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
        end else if (frame_start) begin
            found_q <= 1'b0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
        end else if (upd) begin
            found_q <= 1'b1;
            if (!found_q) begin
                xmin_q <= x_lo;
                xmax_q <= l_x;
                ymin_q <= l_y;
                ymax_q <= l_y;
            end else begin
                if (x_lo < xmin_q) xmin_q <= x_lo;
                if (l_x > xmax_q)  xmax_q <= l_x;
                if (l_y < ymin_q)  ymin_q <= l_y;
                if (l_y > ymax_q)  ymax_q <= l_y;
            end
        end
    end

    assign Box_Valid = box_vld_q;
    assign Box_Found = res_q.found;
    assign Frame_Err = res_q.err;
    assign X_Min     = res_q.xmin;
    assign X_Max     = res_q.xmax;
    assign Y_Min     = res_q.ymin;
    assign Y_Max     = res_q.ymax;

endmodule

// File: doc/digit_bbox_detect.md
Name: digit_bbox_detect

Overview:
- Per-frame bounding-box finder for the handwritten digit.
- Sits directly downstream of DVP_Capture in the camera PCLK domain, in parallel with the SDRAM write port. Consumes the same DataValid / DataPixel / ImageState stream.
- Binarizes each RGB565 pixel by luma threshold and tracks the min/max X/Y of dark pixels.
- At frame end, publishes the box as a one-cycle result for the overlay/recognition stages.

Parameters:
- IMAGE_WIDTH, 1280, active pixels per line.
- IMAGE_HEIGHT, 720, active lines per frame.
- THRESH, 8'd96, luma below this value is "dark" (digit ink).
- RUN_MIN, 3, consecutive dark pixels required when the noise filter is compiled in.

Ports:
- Clk  in  1  pixel clock (camera PCLK).
- Rst  in  1  asynchronous, active-high reset.
- ImageState  in  1  high = between frames (inter-frame / FIFO clear), low = frame active.
- DataValid  in  1  pixel strobe.
- DataPixel  in  16  RGB565 pixel {R5,G6,B5}.
- Box_Valid  out  1  one-cycle pulse, result registers updated.
- Box_Found  out  1  at least one dark pixel in the last frame.
- Frame_Err  out  1  last frame pixel count != IMAGE_WIDTH*IMAGE_HEIGHT.
- X_Min, X_Max  out  11  box columns, 0-based.
- Y_Min, Y_Max  out  10  box rows, 0-based.

Behaviour:
- Clock and reset: one clock, Clk. Rst is asynchronous, active-high.
- Reset values: all outputs 0; FSM = WAIT_SYNC; counters and trackers cleared.
- FSM states:
  - WAIT_SYNC: stay until ImageState=1 is sampled. This discards any partial frame after reset.
  - IDLE: wait for ImageState 1->0. On that edge, clear x/y counters, trackers and pixel count, then go to ACTIVE.
  - ACTIVE: accept pixels. On ImageState 0->1, go to DRAIN.
  - DRAIN: wait 3 cycles, then go to PUBLISH.
  - PUBLISH: one cycle. Load the result registers, assert Box_Valid, return to IDLE.
- Pixel acceptance: only when DataValid=1, state=ACTIVE and ImageState=0. DataValid in any other state, or in the cycle ImageState is high, is ignored.
- Position counters:
  - x increments per accepted pixel and wraps IMAGE_WIDTH-1 -> 0 with y++.
  - Once y reaches IMAGE_HEIGHT, pixels still count toward the total but do not update the trackers.
  - The total counter saturates at 2^21-1.
- Luma pipeline:
  - Stage 1: register the expansion R8={R5,3'b0}, G8={G6,2'b0}, B8={B5,3'b0}, plus x, y and valid.
  - Stage 2: Y = (77*R8 + 150*G8 + 29*B8) >> 8. Unsigned 16-bit sum, 8-bit result, dark = Y < THRESH.
  - Stage 3: tracker update.
  - Latency from DataValid to tracker update: 3 cycles. DRAIN covers this.
- Tracker update on a dark pixel:
  - If none found yet: Xmin=Xmax=x, Ymin=Ymax=y.
  - Otherwise min/max update with unsigned compares.
- PUBLISH outputs:
  - Box_Found = found flag.
  - Coordinates = trackers if found, all zero if not.
  - Frame_Err = (count != W*H).
  - Outputs hold until the next PUBLISH.
- Abnormal ImageState:
  - ImageState re-falls during DRAIN: abort the drain, publish nothing, start a new frame.
  - Rst mid-frame: immediate clear, back to WAIT_SYNC. No Box_Valid for the interrupted frame.

Optional Feature:
- Macro: BBOX_NOISE_FILTER_EN.
- Defined:
  - A run counter (saturating at RUN_MIN) counts consecutive dark pixels within a line. It resets on a light pixel and at x wrap.
  - The tracker is updated only when the run reaches RUN_MIN. The update uses the x of the run start (x-RUN_MIN+1) for the min compare and the current x for the max compare.
  - Isolated dark specks of fewer than RUN_MIN pixels are ignored.
- Undefined: every dark pixel updates the tracker; no run counter is synthesized.

Decomposition:
- Shared package bbox_pkg:
  - Luma coefficients 77/150/29.
  - Coordinate widths (11/10).
  - FSM state enum {WAIT_SYNC, IDLE, ACTIVE, DRAIN, PUBLISH}.
  - Box result struct {found, err, xmin, xmax, ymin, ymax}.
- One sub-module, rgb565_luma: the two-stage pipelined RGB565-to-8-bit luma with a valid/x/y sideband, reusable by later threshold stages.

Test Plan:
- Reset, then ImageState high->low, then a full 1280x720 frame of 16'hFFFF (Y=250), then ImageState high -> one Box_Valid 4 cycles after the rise, Box_Found=0, coordinates 0, Frame_Err=0.
- White frame with 16'h0000 at (100,50) and (900,600), filter undefined -> X_Min=100, X_Max=900, Y_Min=50, Y_Max=600, Box_Found=1.
- Same frame with BBOX_NOISE_FILTER_EN, RUN_MIN=3 -> Box_Found=0. Then add a dark run x=200..204 on y=10 -> box (200,204,10,10).
- Frame truncated to 1280x719 pixels -> Frame_Err=1, box still reported. Frame of 1280x721 -> Frame_Err=1, line 720 ignored by the trackers.
- Rst asserted mid-frame, then ImageState low mid-frame -> no Box_Valid until a full ImageState high->low->high cycle completes.
- DataValid pulses while ImageState=1 carrying 16'h0000 -> no effect on the trackers or the pixel count.
